// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-halfword SRAM data-memory controller.
package sram_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic LOW_HALF  = 1'b0;
  localparam logic HIGH_HALF = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable wait-state down-counter; zero flag is registered alongside the count.
module sram_wait_counter
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count_next_c,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_comb begin
    count_next_c = count;
    if (load) begin
      count_next_c = load_value;
    end else if (dec && (count != '0)) begin
      count_next_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_next_c;
      zero  <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory responder: each 32-bit access becomes two 16-bit SRAM
// accesses with WAIT_CYCLES wait states. Optional read buffer: SRAM_CTRL_READ_BUFFER_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES     = 2,
  parameter int unsigned BASE_ADDRESS    = 1024,
  parameter int unsigned SRAM_ADDR_WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_Sig_Memory_Read_Enable,
  input  logic                       i_Sig_Memory_Write_Enable,
  input  logic [31:0]                i_Address,
  input  logic [31:0]                i_Write_Data,
  output logic [31:0]                o_Read_Data,
  output logic                       o_Ready,
  output logic [SRAM_ADDR_WIDTH-1:0] o_SRAM_Address,
  output logic [15:0]                o_SRAM_Write_Data,
  input  logic [15:0]                i_SRAM_Read_Data,
  output logic                       o_SRAM_Data_Drive,
  output logic                       o_SRAM_WE_N
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e           state, state_nxt;
  logic             req, hit;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      in_word;
  logic             op_wr_q;
  logic [31:0]      word_q, wdata_q;
  logic             cur_wr;
  logic [31:0]      cur_word, cur_wdata;
  logic             phase_nxt;

  assign req     = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
  assign in_word = (i_Address - 32'(BASE_ADDRESS)) >> 2;

  // In IDLE the request comes straight from the pins; afterwards from the latched copy.
  assign cur_wr    = (state == ST_IDLE) ? i_Sig_Memory_Write_Enable : op_wr_q;
  assign cur_word  = (state == ST_IDLE) ? in_word : word_q;
  assign cur_wdata = (state == ST_IDLE) ? i_Write_Data : wdata_q;
  assign phase_nxt = (state_nxt == ST_LOW) || (state_nxt == ST_HIGH);

  function automatic logic [SRAM_ADDR_WIDTH-1:0] half_addr(input logic [31:0] word,
                                                           input logic half);
    return SRAM_ADDR_WIDTH'({word, half});
  endfunction

  sram_wait_counter u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .dec          (cnt_dec),
    .load_value   (RELOAD),
    .count_next_c (cnt_next),
    .zero         (cnt_zero)
  );

  // Next-state, counter control and the combinational ready.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    o_Ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        o_Ready = !req || hit;
        if (req && !hit) begin
          cnt_load  = 1'b1;
          state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          state_nxt = ST_HIGH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        o_Ready   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from next-state so they line up with each phase cycle;
  // WE_N releases on the final cycle of a phase to give address/data hold time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      op_wr_q           <= 1'b0;
      word_q            <= '0;
      wdata_q           <= '0;
      o_Read_Data       <= '0;
      o_SRAM_Address    <= '0;
      o_SRAM_Write_Data <= '0;
      o_SRAM_Data_Drive <= 1'b0;
      o_SRAM_WE_N       <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && req && !hit) begin
        op_wr_q <= i_Sig_Memory_Write_Enable;
        word_q  <= in_word;
        wdata_q <= i_Write_Data;
      end
      if (phase_nxt) begin
        o_SRAM_Address    <= half_addr(cur_word, (state_nxt == ST_HIGH) ? HIGH_HALF : LOW_HALF);
        o_SRAM_Write_Data <= (state_nxt == ST_HIGH) ? cur_wdata[31:16] : cur_wdata[15:0];
      end
      o_SRAM_Data_Drive <= phase_nxt && cur_wr;
      o_SRAM_WE_N       <= !(phase_nxt && cur_wr && (cnt_next != '0));
      if (!op_wr_q && cnt_zero) begin
        if (state == ST_LOW)  o_Read_Data[15:0]  <= i_SRAM_Read_Data;
        if (state == ST_HIGH) o_Read_Data[31:16] <= i_SRAM_Read_Data;
      end
    end
  end

`ifdef SRAM_CTRL_READ_BUFFER_EN
  logic        buf_valid;
  logic [31:0] buf_tag;

  assign hit = buf_valid && i_Sig_Memory_Read_Enable && !i_Sig_Memory_Write_Enable &&
               (buf_tag == in_word);

  // One-entry buffer over o_Read_Data: filled by reads, invalidated by matching writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else if (state == ST_DONE) begin
      if (op_wr_q) begin
        if (word_q == buf_tag) buf_valid <= 1'b0;
      end else begin
        buf_valid <= 1'b1;
        buf_tag   <= word_q;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a behavioural async SRAM.
module tb_sram_controller;

  localparam int unsigned WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rd = 1'b0, i_wr = 1'b0;
  logic [31:0] i_Address = '0, i_Write_Data = '0;
  logic [31:0] o_Read_Data;
  logic        o_Ready;
  logic [17:0] o_SRAM_Address;
  logic [15:0] o_SRAM_Write_Data, i_SRAM_Read_Data;
  logic        o_SRAM_Data_Drive, o_SRAM_WE_N;

  logic [15:0] mem [0:63];
  int pass_cnt = 0;
  int check_cnt = 0;

  sram_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDRESS(1024), .SRAM_ADDR_WIDTH(18)) dut (
    .clk(clk), .reset(reset),
    .i_Sig_Memory_Read_Enable(i_rd), .i_Sig_Memory_Write_Enable(i_wr),
    .i_Address(i_Address), .i_Write_Data(i_Write_Data),
    .o_Read_Data(o_Read_Data), .o_Ready(o_Ready),
    .o_SRAM_Address(o_SRAM_Address), .o_SRAM_Write_Data(o_SRAM_Write_Data),
    .i_SRAM_Read_Data(i_SRAM_Read_Data), .o_SRAM_Data_Drive(o_SRAM_Data_Drive),
    .o_SRAM_WE_N(o_SRAM_WE_N)
  );

  always #5 clk = ~clk;

  assign i_SRAM_Read_Data = mem[o_SRAM_Address[5:0]];

  always @(negedge clk) begin
    if (o_SRAM_WE_N === 1'b0) mem[o_SRAM_Address[5:0]] <= o_SRAM_Write_Data;
  end

  always @(posedge clk) begin
    if (!reset && i_wr) assert (WAIT >= 2) else $error("writes need WAIT_CYCLES >= 2");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait for completion, recording pin activity per cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output int cycles, output int we_cnt,
                           output logic [17:0] wa0, output logic [17:0] wa1,
                           output logic [15:0] wd0, output logic [15:0] wd1,
                           output logic drive_ok, output int addr_changes);
    logic [17:0] prev;
    i_rd = rd; i_wr = wr; i_Address = addr; i_Write_Data = data;
    #1;
    cycles = 0; we_cnt = 0; drive_ok = 1'b1; addr_changes = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    prev = o_SRAM_Address;
    while (o_Ready !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
      if (o_SRAM_Address !== prev) addr_changes++;
      prev = o_SRAM_Address;
      if (o_Ready !== 1'b1) begin
        if (o_SRAM_Data_Drive !== wr) drive_ok = 1'b0;
        if (o_SRAM_WE_N === 1'b0) begin
          if (we_cnt == 0) begin wa0 = o_SRAM_Address; wd0 = o_SRAM_Write_Data; end
          else begin wa1 = o_SRAM_Address; wd1 = o_SRAM_Write_Data; end
          we_cnt++;
        end
      end
    end
    i_rd = 1'b0; i_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    check_cnt++; if (o_Read_Data !== 32'h0) $display("FAIL reset_rdata got %h want 0", o_Read_Data); else pass_cnt++;
    check_cnt++; if (o_SRAM_Address !== 18'h0) $display("FAIL reset_addr got %h want 0", o_SRAM_Address); else pass_cnt++;
    check_cnt++; if (o_SRAM_Write_Data !== 16'h0) $display("FAIL reset_wdata got %h want 0", o_SRAM_Write_Data); else pass_cnt++;
    check_cnt++; if (o_SRAM_Data_Drive !== 1'b0) $display("FAIL reset_drive got %b want 0", o_SRAM_Data_Drive); else pass_cnt++;
    check_cnt++; if (o_SRAM_WE_N !== 1'b1) $display("FAIL reset_we_n got %b want 1", o_SRAM_WE_N); else pass_cnt++;
    check_cnt++; if (o_Ready !== 1'b1) $display("FAIL reset_ready_noreq got %b want 1", o_Ready); else pass_cnt++;
    i_rd = 1'b1; #1;
    check_cnt++; if (o_Ready !== 1'b0) $display("FAIL reset_ready_req got %b want 0", o_Ready); else pass_cnt++;
    i_rd = 1'b0;
    @(negedge clk); reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    int cyc, wec, ach; logic [17:0] a0, a1; logic [15:0] d0, d1; logic dok;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (cyc !== 5) $display("FAIL read_latency got %0d want 5", cyc); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h22221111) $display("FAIL read_data got %h want 22221111", o_Read_Data); else pass_cnt++;
    check_cnt++; if (wec !== 0) $display("FAIL read_we_pulses got %0d want 0", wec); else pass_cnt++;
    check_cnt++; if (dok !== 1'b1) $display("FAIL read_drive got %b want 1(ok)", dok); else pass_cnt++;
    step();
  endtask

  task automatic test_write();
    int cyc, wec, ach; logic [17:0] a0, a1; logic [15:0] d0, d1; logic dok;
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (cyc !== 5) $display("FAIL write_latency got %0d want 5", cyc); else pass_cnt++;
    check_cnt++; if (wec !== 2) $display("FAIL write_we_pulses got %0d want 2", wec); else pass_cnt++;
    check_cnt++; if (a0 !== 18'd4 || d0 !== 16'hBEEF) $display("FAIL write_low got %0d/%h want 4/beef", a0, d0); else pass_cnt++;
    check_cnt++; if (a1 !== 18'd5 || d1 !== 16'hDEAD) $display("FAIL write_high got %0d/%h want 5/dead", a1, d1); else pass_cnt++;
    check_cnt++; if (dok !== 1'b1) $display("FAIL write_drive got %b want 1(ok)", dok); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h22221111) $display("FAIL write_rdata_hold got %h want 22221111", o_Read_Data); else pass_cnt++;
    step();
    check_cnt++; if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) $display("FAIL write_mem got %h%h want deadbeef", mem[5], mem[4]); else pass_cnt++;
  endtask

  task automatic test_read_write_both();
    int cyc, wec, ach; logic [17:0] a0, a1; logic [15:0] d0, d1; logic dok;
    do_access(1'b1, 1'b1, 32'd1028, 32'h5555AAAA, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (wec !== 2) $display("FAIL both_we_pulses got %0d want 2", wec); else pass_cnt++;
    check_cnt++; if (a0 !== 18'd2 || d0 !== 16'hAAAA) $display("FAIL both_low got %0d/%h want 2/aaaa", a0, d0); else pass_cnt++;
    check_cnt++; if (a1 !== 18'd3 || d1 !== 16'h5555) $display("FAIL both_high got %0d/%h want 3/5555", a1, d1); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h22221111) $display("FAIL both_rdata_hold got %h want 22221111", o_Read_Data); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_write();
    i_wr = 1'b1; i_Address = 32'd1036; i_Write_Data = 32'h12345678;
    repeat (3) step();
    check_cnt++; if (o_SRAM_WE_N !== 1'b0 || o_SRAM_Address !== 18'd7) $display("FAIL midrst_high_phase got we_n=%b addr=%0d want 0/7", o_SRAM_WE_N, o_SRAM_Address); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    check_cnt++; if (o_SRAM_WE_N !== 1'b1) $display("FAIL midrst_we_n got %b want 1", o_SRAM_WE_N); else pass_cnt++;
    check_cnt++; if (o_SRAM_Data_Drive !== 1'b0) $display("FAIL midrst_drive got %b want 0", o_SRAM_Data_Drive); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h0) $display("FAIL midrst_rdata got %h want 0", o_Read_Data); else pass_cnt++;
    check_cnt++; if (o_Ready !== 1'b0) $display("FAIL midrst_ready_req got %b want 0", o_Ready); else pass_cnt++;
    i_wr = 1'b0; #1;
    check_cnt++; if (o_Ready !== 1'b1) $display("FAIL midrst_idle got %b want 1", o_Ready); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    step();
    check_cnt++; if (o_Ready !== 1'b1 || o_SRAM_WE_N !== 1'b1) $display("FAIL midrst_after got rdy=%b we_n=%b want 1/1", o_Ready, o_SRAM_WE_N); else pass_cnt++;
  endtask

`ifdef SRAM_CTRL_READ_BUFFER_EN
  task automatic test_read_buffer();
    int cyc, wec, ach; logic [17:0] a0, a1; logic [15:0] d0, d1; logic dok;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (cyc !== 5) $display("FAIL buf_miss_latency got %0d want 5", cyc); else pass_cnt++;
    step();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (cyc !== 0) $display("FAIL buf_hit_latency got %0d want 0", cyc); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h22221111) $display("FAIL buf_hit_data got %h want 22221111", o_Read_Data); else pass_cnt++;
    step();
    check_cnt++; if (o_SRAM_Address !== 18'd1) $display("FAIL buf_hit_addr got %0d want 1", o_SRAM_Address); else pass_cnt++;
    do_access(1'b0, 1'b1, 32'd1024, 32'h33334444, cyc, wec, a0, a1, d0, d1, dok, ach);
    step();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, cyc, wec, a0, a1, d0, d1, dok, ach);
    check_cnt++; if (cyc !== 5) $display("FAIL buf_inval_latency got %0d want 5", cyc); else pass_cnt++;
    check_cnt++; if (o_Read_Data !== 32'h33334444) $display("FAIL buf_inval_data got %h want 33334444", o_Read_Data); else pass_cnt++;
    step();
  endtask
`else
  task automatic test_back_to_back();
    int first, second;
    logic bubble_rdy;
    logic [31:0] d1, d2;
    first = -1; second = -1; bubble_rdy = 1'bx; d1 = '0; d2 = '0;
    i_rd = 1'b1; i_Address = 32'd1024;
    #1;
    for (int c = 0; c < 30 && second < 0; c++) begin
      if (first >= 0 && c == first + 1) bubble_rdy = o_Ready;
      if (o_Ready === 1'b1) begin
        if (first < 0) begin
          first = c; d1 = o_Read_Data; i_Address = 32'd1028;
        end else begin
          second = c; d2 = o_Read_Data;
        end
      end
      if (second < 0) step();
    end
    i_rd = 1'b0;
    check_cnt++; if (first !== 5) $display("FAIL b2b_first got %0d want 5", first); else pass_cnt++;
    check_cnt++; if (second !== 11) $display("FAIL b2b_total got %0d want 11", second); else pass_cnt++;
    check_cnt++; if (bubble_rdy !== 1'b0) $display("FAIL b2b_bubble got %b want 0", bubble_rdy); else pass_cnt++;
    check_cnt++; if (d1 !== 32'h22221111) $display("FAIL b2b_data1 got %h want 22221111", d1); else pass_cnt++;
    check_cnt++; if (d2 !== 32'h5555AAAA) $display("FAIL b2b_data2 got %h want 5555aaaa", d2); else pass_cnt++;
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    test_reset();
    test_read();
    test_write();
    test_read_write_both();
    test_reset_mid_write();
`ifdef SRAM_CTRL_READ_BUFFER_EN
    test_read_buffer();
`else
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder for the MEM stage's data-memory requests. Each 32-bit word access is split into two 16-bit accesses on an external asynchronous SRAM, each with programmable wait states. While an access is in progress the block holds `o_Ready` low, and the top level uses this as the pipeline freeze. It sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles per 16-bit half access; legal range 1–15.
- `BASE_ADDRESS`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_ADDR_WIDTH`, default 18: halfword address width on the pins.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_Sig_Memory_Read_Enable`  in  1  read request from MEM stage.
- `i_Sig_Memory_Write_Enable`  in  1  write request from MEM stage.
- `i_Address`  in  32  byte address (ALU result).
- `i_Write_Data`  in  32  store data (Rm value).
- `o_Read_Data`  out  32  load result; registered.
- `o_Ready`  out  1  high when the current request completes this cycle, or when no request is present.
- `o_SRAM_Address`  out  `SRAM_ADDR_WIDTH`  halfword address.
- `o_SRAM_Write_Data`  out  16  data driven to pins.
- `i_SRAM_Read_Data`  in  16  data from pins.
- `o_SRAM_Data_Drive`  out  1  tristate enable for the pin driver.
- `o_SRAM_WE_N`  out  1  active-low write strobe.

## Operation
- Request: `req = rd | wr`. If both are asserted, the write wins.
- Address mapping:
  - `word = (i_Address - BASE_ADDRESS) >> 2`.
  - Low half at `{word, 1'b0}`, high half at `{word, 1'b1}`, truncated to `SRAM_ADDR_WIDTH`.
  - Bits [1:0] of the address are ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: on `req` (and not a buffer hit), load the wait counter with `WAIT_CYCLES-1` and go to LOW.
  - LOW: drive the low-half address. Counter decrements each cycle; at 0, reload it and go to HIGH.
  - HIGH: same as LOW for the high half; at 0, go to DONE.
  - DONE: `o_Ready=1` for exactly one cycle, then IDLE.
- Write phases (LOW/HIGH):
  - `o_SRAM_Data_Drive=1`; `o_SRAM_Write_Data` is `i_Write_Data[15:0]` in LOW and `[31:16]` in HIGH.
  - `o_SRAM_WE_N=0` in every phase cycle except the last; address and data stay stable through that final cycle (hold time).
- Read phases: `Drive=0`, `WE_N=1`. `i_SRAM_Read_Data` is captured on the last cycle of LOW into bits [15:0], and on the last cycle of HIGH into [31:16], of `o_Read_Data`.
- `o_Ready = !req` in IDLE, `0` in LOW/HIGH, `1` in DONE (combinational from state and inputs).
- The MEM stage holds the request stable while `o_Ready=0`. The block does not re-sample the address or data mid-access.
- `o_Read_Data` holds its value across writes and idle cycles; it only changes on read capture.

## Timing
- Reset values:
  - FSM state IDLE, counter 0.
  - `o_Read_Data=0`, `o_SRAM_Address=0`, `o_SRAM_Write_Data=0`, `o_SRAM_Data_Drive=0`, `o_SRAM_WE_N=1`.
  - Hit buffer invalid.
  - `o_Ready` is `!req` after reset.
- Access latency: a request first seen in IDLE at cycle 0 gives `o_Ready` low for cycles 0 .. 2·`WAIT_CYCLES`, and high at cycle 2·`WAIT_CYCLES`+1 (DONE).
- Read data is valid in the DONE cycle, so the MEM stage register captures it at the end of DONE.
- Back-to-back requests: DONE → IDLE. A new request sampled in IDLE costs one bubble cycle (IDLE, with `o_Ready=0`).
- Reset asserted mid-access:
  - Immediate return to IDLE, `WE_N=1`, `Drive=0`.
  - A partial write is abandoned and its SRAM contents are undefined.
  - No completion is signalled.
- With `WAIT_CYCLES=1`, `WE_N` is never asserted. This is illegal for writes; writes require `WAIT_CYCLES≥2`, and the bench checks this with an assertion.

## Configuration
- Macro `SRAM_CTRL_READ_BUFFER_EN`.
- Defined:
  - A one-entry read buffer: valid bit plus 32-bit word-address tag; the data is the `o_Read_Data` register.
  - The tag and valid bit are set on every completed read.
  - In IDLE, a read whose word address equals the tag while valid is a hit: `o_Ready=1` the same cycle, no SRAM cycle, state stays IDLE.
  - A write to a matching word address clears valid at DONE.
- Undefined: every read performs the full SRAM access, and no buffer state exists.

## Structure
- Package `sram_ctrl_pkg`: the FSM state encoding (IDLE/LOW/HIGH/DONE), the half-select constants LOW_HALF=0 and HIGH_HALF=1, and the 4-bit counter width constant.
- Sub-module `sram_wait_counter`: loadable down-counter with a `zero` flag. It is instantiated once and reloaded per phase.

## Test plan
- Read, `WAIT_CYCLES=2`, addr 1024, SRAM halfwords 0x1111 at addr 0 and 0x2222 at addr 1 -> `o_Ready` low for 5 cycles, `o_Read_Data=0x22221111` in DONE.
- Write 0xDEADBEEF to addr 1032 -> `WE_N` low for 1 cycle at SRAM addr 4 with data 0xBEEF, then at addr 5 with data 0xDEAD. `Drive` stays high through both phases.
- Read and write asserted together at addr 1028 -> a write occurs and `o_Read_Data` is unchanged.
- Reset pulse during the HIGH phase of a write -> `WE_N=1` and `Drive=0` asynchronously, state IDLE, `o_Read_Data=0`.
- With `SRAM_CTRL_READ_BUFFER_EN`: read 1024 twice -> the second read has `o_Ready=1` in its first cycle with no address toggling. Then write 1024 and read 1024 -> full 5-cycle access.
- Two back-to-back reads at 1024 and 1028 without the macro -> 11 cycles in total, including one IDLE bubble.
